chess_key_conditioner: RTL and testbench

CHESS_KEY_CONDITIONER -- requirements
Module: chess_key_conditioner

---
 rtl/chess_pkg.sv | 41 ++++
 rtl/key_debouncer.sv | 42 ++++
 rtl/chess_key_conditioner.sv | 168 ++++++++++++++++
 tb/tb_chess_key_conditioner.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types for the chess board cursor keys: active-low ON/OFF levels, direction and FSM state.
// KEY_AUTOREPEAT_EN adds the REPEAT state used by the auto-repeat build.
package chess_pkg;

    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;

    typedef enum logic [2:0] {
        NONE,
        LEFT,
        RIGHT,
        UP,
        DOWN
    } dirType;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
`ifdef KEY_AUTOREPEAT_EN
        HOLD,
        REPEAT
`else
        HOLD
`endif
    } stateType;

    // Active-low {Left, Right, Up, Down} pattern with only the given direction ON.
    function automatic logic [3:0] dirToKeys(input dirType dir);
        logic [3:0] keys;
        keys = {4{OFF}};
        case (dir)
            LEFT:    keys[3] = ON;
            RIGHT:   keys[2] = ON;
            UP:      keys[1] = ON;
            DOWN:    keys[0] = ON;
            default: keys = {4{OFF}};
        endcase
        return keys;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a debouncer that accepts a new level only after
// DEBOUNCE_SAMPLES consecutive differing samples; RESET_LEVEL is the released level.
module key_debouncer
    import chess_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 2,
    parameter logic        RESET_LEVEL      = OFF
) (
    input  logic OutClock,
    input  logic resetApp,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] diffCnt;

    // Any sample that matches the stable level restarts the run of differing samples.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            sync1   <= RESET_LEVEL;
            sync2   <= RESET_LEVEL;
            level   <= RESET_LEVEL;
            diffCnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                diffCnt <= '0;
            end else if (diffCnt == CNT_W'(DEBOUNCE_SAMPLES - 1)) begin
                level   <= sync2;
                diffCnt <= '0;
            end else begin
                diffCnt <= diffCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/chess_key_conditioner.sv
// Conditions four cursor push-buttons into one-cycle active-low step pulses and debounces the lock switch.
// Define KEY_AUTOREPEAT_EN to build the HOLD/REPEAT auto-repeat behaviour.
module chess_key_conditioner
    import chess_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 2,
    parameter int unsigned REPEAT_DELAY     = 5,
    parameter int unsigned REPEAT_PERIOD    = 2
) (
    input  logic OutClock,
    input  logic resetApp,
    input  logic KeyLeftRaw,
    input  logic KeyRightRaw,
    input  logic KeyUpRaw,
    input  logic KeyDownRaw,
    input  logic LockSwitchRaw,
    output logic KeyLeft,
    output logic KeyRight,
    output logic KeyUp,
    output logic KeyDown,
    output logic LockSwitch
);

    if (DEBOUNCE_SAMPLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : gBadParams
        $error("chess_key_conditioner: all timing parameters must be >= 1");
    end

    logic [3:0] keyRaw;
    logic [3:0] keyLevel;
    logic       lockLevel;

    assign keyRaw = {KeyLeftRaw, KeyRightRaw, KeyUpRaw, KeyDownRaw};

    for (genvar i = 0; i < 4; i++) begin : gKey
        key_debouncer #(
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
            .RESET_LEVEL      (OFF)
        ) uKeyDebouncer (
            .OutClock (OutClock),
            .resetApp (resetApp),
            .raw      (keyRaw[i]),
            .level    (keyLevel[i])
        );
    end

    key_debouncer #(
        .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
        .RESET_LEVEL      (1'b0)
    ) uLockDebouncer (
        .OutClock (OutClock),
        .resetApp (resetApp),
        .raw      (LockSwitchRaw),
        .level    (lockLevel)
    );

    dirType selDir;

    // Fixed priority Left > Right > Up > Down.
    always_comb begin
        selDir = NONE;
        if (keyLevel[3] == ON) begin
            selDir = LEFT;
        end else if (keyLevel[2] == ON) begin
            selDir = RIGHT;
        end else if (keyLevel[1] == ON) begin
            selDir = UP;
        end else if (keyLevel[0] == ON) begin
            selDir = DOWN;
        end
    end

    stateType   state;
    stateType   stateNext;
    dirType     curDir;
    dirType     dirNext;
    dirType     pulseDir;
    logic [3:0] keyOut;
    logic [3:0] keyOutNext;
    logic       lockOut;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] repCnt;
    logic [CNT_W-1:0] repCntNext;
`endif

    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            state   <= IDLE;
            curDir  <= NONE;
            keyOut  <= {4{OFF}};
            lockOut <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            repCnt  <= '0;
`endif
        end else begin
            state   <= stateNext;
            curDir  <= dirNext;
            keyOut  <= keyOutNext;
            lockOut <= lockLevel;
`ifdef KEY_AUTOREPEAT_EN
            repCnt  <= repCntNext;
`endif
        end
    end

    // A selection change overrides every state; the registered pulse lands in the PRESS cycle.
    always_comb begin
        stateNext = state;
        dirNext   = curDir;
        pulseDir  = NONE;
`ifdef KEY_AUTOREPEAT_EN
        repCntNext = repCnt;
`endif
        if (selDir != curDir) begin
            dirNext   = selDir;
            stateNext = (selDir == NONE) ? IDLE : PRESS;
            pulseDir  = selDir;
`ifdef KEY_AUTOREPEAT_EN
            repCntNext = '0;
`endif
        end else begin
            case (state)
                IDLE: stateNext = IDLE;
`ifdef KEY_AUTOREPEAT_EN
                PRESS: begin
                    if (REPEAT_DELAY == 1) begin
                        stateNext  = REPEAT;
                        pulseDir   = curDir;
                        repCntNext = CNT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        stateNext  = HOLD;
                        repCntNext = CNT_W'(REPEAT_DELAY - 2);
                    end
                end
                HOLD: begin
                    if (repCnt == '0) begin
                        stateNext  = REPEAT;
                        pulseDir   = curDir;
                        repCntNext = CNT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        repCntNext = repCnt - CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (repCnt == '0) begin
                        pulseDir   = curDir;
                        repCntNext = CNT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        repCntNext = repCnt - CNT_W'(1);
                    end
                end
`else
                PRESS: stateNext = HOLD;
                HOLD:  stateNext = HOLD;
`endif
                default: stateNext = IDLE;
            endcase
        end
        keyOutNext = dirToKeys(pulseDir);
    end

    assign {KeyLeft, KeyRight, KeyUp, KeyDown} = keyOut;
    assign LockSwitch = lockOut;

endmodule

// File: tb/tb_chess_key_conditioner.sv
// Randomized and directed bench for chess_key_conditioner against a sample-window / pulse-age model.
// Honours KEY_AUTOREPEAT_EN when it is defined for the whole build.
module tb_chess_key_conditioner;

    localparam int DEB     = 2;
    localparam int RDELAY  = 5;
    localparam int RPERIOD = 2;

    logic OutClock;
    logic resetApp;
    logic KeyLeftRaw, KeyRightRaw, KeyUpRaw, KeyDownRaw, LockSwitchRaw;
    logic KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch;

    int assertions = 0;
    int failures   = 0;

    chess_key_conditioner #(
        .DEBOUNCE_SAMPLES (DEB),
        .REPEAT_DELAY     (RDELAY),
        .REPEAT_PERIOD    (RPERIOD)
    ) dut (
        .OutClock      (OutClock),
        .resetApp      (resetApp),
        .KeyLeftRaw    (KeyLeftRaw),
        .KeyRightRaw   (KeyRightRaw),
        .KeyUpRaw      (KeyUpRaw),
        .KeyDownRaw    (KeyDownRaw),
        .LockSwitchRaw (LockSwitchRaw),
        .KeyLeft       (KeyLeft),
        .KeyRight      (KeyRight),
        .KeyUp         (KeyUp),
        .KeyDown       (KeyDown),
        .LockSwitch    (LockSwitch)
    );

    initial OutClock = 1'b0;
    always #5 OutClock = ~OutClock;

    // Model inputs packed as {Left, Right, Up, Down, Lock}.
    logic [4:0]     mDly1, mDly2, mDeb;
    logic [DEB-1:0] mHist [5];
    int             mLast, mAge;
    logic [3:0]     expKeys;
    logic           expLock;

    function automatic int selOf(input logic [4:0] deb);
        if (!deb[4]) return 1;
        if (!deb[3]) return 2;
        if (!deb[2]) return 3;
        if (!deb[1]) return 4;
        return 0;
    endfunction

    task automatic modelReset();
        mDly1 = 5'b11110;
        mDly2 = 5'b11110;
        mDeb  = 5'b11110;
        for (int i = 0; i < 5; i++) mHist[i] = mDeb[i] ? {DEB{1'b1}} : {DEB{1'b0}};
        mLast   = 0;
        mAge    = 0;
        expKeys = 4'hF;
        expLock = 1'b0;
    endtask

    // One clock edge: the model consumes the raw inputs present at the edge, then settles 1 time unit.
    task automatic tick();
        logic [4:0] r;
        int         s;
        bit         pulse;
        @(posedge OutClock);
        r = {KeyLeftRaw, KeyRightRaw, KeyUpRaw, KeyDownRaw, LockSwitchRaw};
        s = selOf(mDeb);
        if (s != mLast) mAge = 0;
        else mAge++;
        mLast = s;
        pulse = (mAge == 0);
`ifdef KEY_AUTOREPEAT_EN
        if (mAge == RDELAY || (mAge > RDELAY && ((mAge - RDELAY) % RPERIOD) == 0)) pulse = 1'b1;
`endif
        if (s == 0) pulse = 1'b0;
        expKeys = 4'hF;
        if (pulse) expKeys[4 - s] = 1'b0;
        expLock = mDeb[0];
        for (int i = 0; i < 5; i++) begin
            mHist[i] = {mHist[i][DEB-2:0], mDly2[i]};
            if (mHist[i] == {DEB{~mDeb[i]}}) mDeb[i] = ~mDeb[i];
        end
        mDly2 = mDly1;
        mDly1 = r;
        #1;
    endtask

    task automatic releaseAll();
        KeyLeftRaw = 1'b1; KeyRightRaw = 1'b1; KeyUpRaw = 1'b1; KeyDownRaw = 1'b1;
        LockSwitchRaw = 1'b0;
    endtask

    task automatic settle();
        releaseAll();
        repeat (12) tick();
    endtask

    task automatic test_reset();
        releaseAll();
        resetApp = 1'b1;
        modelReset();
        repeat (3) @(posedge OutClock);
        #1;
        assertions++;
        if ({KeyLeft, KeyRight, KeyUp, KeyDown} !== 4'hF) begin
            failures++;
            $display("FAIL reset_keys: got %b expected 1111", {KeyLeft, KeyRight, KeyUp, KeyDown});
        end
        assertions++;
        if (LockSwitch !== 1'b0) begin
            failures++;
            $display("FAIL reset_lock: got %b expected 0", LockSwitch);
        end
        KeyLeftRaw = 1'b0;
        LockSwitchRaw = 1'b1;
        repeat (4) @(posedge OutClock);
        #1;
        assertions++;
        if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_hold_inputs: got %b expected 11110",
                     {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch});
        end
        releaseAll();
        resetApp = 1'b0;
    endtask

    task automatic test_single_press();
        int firstLow = -1;
        int lowCount = 0;
        KeyLeftRaw = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) KeyLeftRaw = 1'b1;
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL single_press cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            if (KeyLeft === 1'b0) begin
                lowCount++;
                if (firstLow < 0) firstLow = k;
            end
        end
        assertions++;
        if (firstLow != 4) begin
            failures++;
            $display("FAIL single_press_latency: got edge +%0d expected +4", firstLow);
        end
        assertions++;
        if (lowCount != 1) begin
            failures++;
            $display("FAIL single_press_count: got %0d pulses expected 1", lowCount);
        end
    endtask

    task automatic test_glitch();
        int lowCount = 0;
        KeyLeftRaw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) KeyLeftRaw = 1'b1;
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL glitch cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            if ({KeyLeft, KeyRight, KeyUp, KeyDown} !== 4'hF) lowCount++;
        end
        assertions++;
        if (lowCount != 0) begin
            failures++;
            $display("FAIL glitch_quiet: got %0d low cycles expected 0", lowCount);
        end
    endtask

    task automatic test_autorepeat();
        int lowCount = 0;
        int firstLow = -1;
        int wantCount;
`ifdef KEY_AUTOREPEAT_EN
        wantCount = 9;
`else
        wantCount = 1;
`endif
        KeyUpRaw = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 20) KeyUpRaw = 1'b1;
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL autorepeat cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            if (KeyUp === 1'b0) begin
                lowCount++;
                if (firstLow < 0) firstLow = k;
            end
        end
        assertions++;
        if (firstLow != 4 || lowCount != wantCount) begin
            failures++;
            $display("FAIL autorepeat_pulses: got first +%0d count %0d expected first +4 count %0d",
                     firstLow, lowCount, wantCount);
        end
    endtask

    task automatic test_priority();
        int firstRight = -1;
        int firstDown  = -1;
        KeyDownRaw  = 1'b0;
        KeyRightRaw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 8)  KeyRightRaw = 1'b1;
            if (k == 20) KeyDownRaw  = 1'b1;
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL priority cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            if (KeyRight === 1'b0 && firstRight < 0) firstRight = k;
            if (KeyDown === 1'b0 && firstDown < 0) firstDown = k;
        end
        assertions++;
        if (firstRight != 4 || firstDown != 12) begin
            failures++;
            $display("FAIL priority_order: got right +%0d down +%0d expected right +4 down +12",
                     firstRight, firstDown);
        end
    endtask

    task automatic test_lock();
        int firstHigh = -1;
        int drops     = 0;
        LockSwitchRaw = 1'b1;
        for (int k = 0; k < 28; k++) begin
            if (k == 10 || k == 12) LockSwitchRaw = 1'b0;
            if (k == 11 || k == 13) LockSwitchRaw = 1'b1;
            if (k == 20) LockSwitchRaw = 1'b0;
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL lock cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            if (LockSwitch === 1'b1 && firstHigh < 0) firstHigh = k;
            if (k >= 4 && k <= 23 && LockSwitch !== 1'b1) drops++;
        end
        assertions++;
        if (firstHigh != 4 || drops != 0) begin
            failures++;
            $display("FAIL lock_levels: got rise +%0d drops %0d expected rise +4 drops 0", firstHigh, drops);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int firstLow = -1;
        KeyLeftRaw = 1'b0;
        repeat (14) tick();
        resetApp = 1'b1;
        modelReset();
        #1;
        assertions++;
        if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== 5'b11110) begin
            failures++;
            $display("FAIL mid_reset_immediate: got %b expected 11110",
                     {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch});
        end
        repeat (2) @(posedge OutClock);
        #1;
        resetApp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL mid_reset cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            if (KeyLeft === 1'b0 && firstLow < 0) firstLow = k;
        end
        assertions++;
        if (firstLow != 4) begin
            failures++;
            $display("FAIL mid_reset_latency: got edge +%0d expected +4", firstLow);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) KeyLeftRaw  = ~KeyLeftRaw;
            if ($urandom_range(0, 5) == 0) KeyRightRaw = ~KeyRightRaw;
            if ($urandom_range(0, 5) == 0) KeyUpRaw    = ~KeyUpRaw;
            if ($urandom_range(0, 5) == 0) KeyDownRaw  = ~KeyDownRaw;
            if ($urandom_range(0, 9) == 0) LockSwitchRaw = ~LockSwitchRaw;
            tick();
            assertions++;
            if ({KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch} !== {expKeys, expLock}) begin
                failures++;
                $display("FAIL random cycle %0d: got %b expected %b", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch}, {expKeys, expLock});
            end
            assertions++;
            if ($countones(~{KeyLeft, KeyRight, KeyUp, KeyDown}) > 1) begin
                failures++;
                $display("FAIL random_one_low cycle %0d: got %b expected at most one 0", k,
                         {KeyLeft, KeyRight, KeyUp, KeyDown});
            end
        end
    endtask

    initial begin
        resetApp = 1'b1;
        releaseAll();
        test_reset();
        settle();
        test_single_press();
        settle();
        test_glitch();
        settle();
        test_autorepeat();
        settle();
        test_priority();
        settle();
        test_lock();
        settle();
        test_reset_mid_repeat();
        settle();
        test_random();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
